eaf_ctrl: RTL and testbench

EAF_CTRL -- requirements
Module: eaf_ctrl

---
 rtl/eaf_pkg.sv | 20 ++
 rtl/eaf_ctrl_if.sv | 33 +++
 rtl/eaf_rr_arb.sv | 42 ++++
 rtl/eaf_ctrl.sv | 151 +++++++++++++++
 tb/tb_eaf_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eaf_pkg.sv
// rtl/eaf_pkg.sv - shared types and default parameters for the eviction address filter controller
package eaf_pkg;

    localparam int EAF_ADDR_W_DEF   = 32;
    localparam int EAF_CAPACITY_DEF = 64;
    localparam int EAF_TIMEOUT_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TEST   = 2'd1,
        ST_INSERT = 2'd2,
        ST_CLEAR  = 2'd3
    } eaf_ctrl_state_t;

    // One-hot grant encoding shared by the arbiter and the controller
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_TEST = 2'b01;
    localparam logic [1:0] GNT_INS  = 2'b10;

endpackage

// File: rtl/eaf_ctrl_if.sv
// rtl/eaf_ctrl_if.sv - command/response bus between the controller and the filter array
interface eaf_ctrl_if
    import eaf_pkg::*;
#(
    parameter int ADDR_W = EAF_ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] eaf_addr_o;
    logic              eaf_test_o;
    logic              eaf_insert_o;
    logic              eaf_clear_o;
    logic              eaf_resp_i;
    logic              eaf_exists_i;

    modport master (
        output eaf_addr_o,
        output eaf_test_o,
        output eaf_insert_o,
        output eaf_clear_o,
        input  eaf_resp_i,
        input  eaf_exists_i
    );

    modport slave (
        input  eaf_addr_o,
        input  eaf_test_o,
        input  eaf_insert_o,
        input  eaf_clear_o,
        output eaf_resp_i,
        output eaf_exists_i
    );

endinterface

// File: rtl/eaf_rr_arb.sv
// rtl/eaf_rr_arb.sv - two-way round-robin arbiter between filter test and insert requests
module eaf_rr_arb
    import eaf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_test_i,
    input  logic       req_ins_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_ins_q;
    logic last_ins_d;

    always_comb begin
        gnt_o      = GNT_NONE;
        last_ins_d = last_ins_q;
        if (en_i) begin
            if (req_test_i && req_ins_i) begin
                gnt_o = last_ins_q ? GNT_TEST : GNT_INS;
            end else if (req_test_i) begin
                gnt_o = GNT_TEST;
            end else if (req_ins_i) begin
                gnt_o = GNT_INS;
            end
        end
        if (gnt_o != GNT_NONE) begin
            last_ins_d = gnt_o[1];
        end
    end

    // Reset as if insert had won last, so a test wins the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_ins_q <= 1'b1;
        end else begin
            last_ins_q <= last_ins_d;
        end
    end

endmodule

// File: rtl/eaf_ctrl.sv
// rtl/eaf_ctrl.sv - sequences L1 test/insert requests onto the eviction address filter
module eaf_ctrl
    import eaf_pkg::*;
#(
    parameter int ADDR_W   = EAF_ADDR_W_DEF,
    parameter int CAPACITY = EAF_CAPACITY_DEF,
    parameter int TIMEOUT  = EAF_TIMEOUT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            test_req_i,
    input  logic [ADDR_W-1:0]               test_addr_i,
    output logic                            test_ack_o,
    output logic                            test_hit_o,
    input  logic                            ins_req_i,
    input  logic [ADDR_W-1:0]               ins_addr_i,
    output logic                            ins_ack_o,
    eaf_ctrl_if.master                      eaf,
    output logic [$clog2(CAPACITY+1)-1:0]   ins_count_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    eaf_ctrl_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic              test_q, test_d;
    logic              ins_q, ins_d;
    logic              clr_q, clr_d;
    logic [1:0]        gnt;
    logic              arb_en;
    logic              wd_expire;

    assign arb_en = (state_q == ST_IDLE);

    eaf_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_test_i (test_req_i),
        .req_ins_i  (ins_req_i),
        .en_i       (arb_en),
        .gnt_o      (gnt)
    );

    // wd_q holds the number of command cycles already spent without a response
    assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        err_d      = err_q;
        test_ack_o = 1'b0;
        test_hit_o = 1'b0;
        ins_ack_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (gnt == GNT_TEST) begin
                    state_d = ST_TEST;
                    addr_d  = test_addr_i;
                end else if (gnt == GNT_INS) begin
                    state_d = ST_INSERT;
                    addr_d  = ins_addr_i;
                end
            end
            ST_TEST: begin
                if (eaf.eaf_resp_i) begin
                    test_ack_o = 1'b1;
                    test_hit_o = eaf.eaf_exists_i;
                    state_d    = ST_IDLE;
                end else if (wd_expire) begin
                    test_ack_o = 1'b1;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_INSERT: begin
                if (eaf.eaf_resp_i) begin
                    ins_ack_o = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = (cnt_q + 1'b1 == CNT_W'(CAPACITY)) ? ST_CLEAR : ST_IDLE;
                end else if (wd_expire) begin
                    ins_ack_o = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A command cut short by reset must never be acknowledged
        if (!rst) begin
            test_ack_o = 1'b0;
            test_hit_o = 1'b0;
            ins_ack_o  = 1'b0;
        end

        test_d = (state_d == ST_TEST);
        ins_d  = (state_d == ST_INSERT);
        clr_d  = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            test_q  <= 1'b0;
            ins_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            test_q  <= test_d;
            ins_q   <= ins_d;
            clr_q   <= clr_d;
        end
    end

    assign eaf.eaf_addr_o   = addr_q;
    assign eaf.eaf_test_o   = test_q;
    assign eaf.eaf_insert_o = ins_q;
    assign eaf.eaf_clear_o  = clr_q;
    assign ins_count_o      = cnt_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign err_o            = err_q;

endmodule

// File: tb/tb_eaf_ctrl.sv
// tb/tb_eaf_ctrl.sv - randomized self-checking bench for eaf_ctrl with a transaction-level filter model
module tb_eaf_ctrl;

    localparam int AW  = 32;
    localparam int CAP = 4;
    localparam int TO  = 16;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          test_req_i = 1'b0;
    logic [AW-1:0] test_addr_i = '0;
    logic          test_ack_o;
    logic          test_hit_o;
    logic          ins_req_i = 1'b0;
    logic [AW-1:0] ins_addr_i = '0;
    logic          ins_ack_o;
    logic [CW-1:0] ins_count_o;
    logic          busy_o;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eaf_ctrl_if #(.ADDR_W(AW)) eaf ();

    eaf_ctrl #(.ADDR_W(AW), .CAPACITY(CAP), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .test_req_i  (test_req_i),
        .test_addr_i (test_addr_i),
        .test_ack_o  (test_ack_o),
        .test_hit_o  (test_hit_o),
        .ins_req_i   (ins_req_i),
        .ins_addr_i  (ins_addr_i),
        .ins_ack_o   (ins_ack_o),
        .eaf         (eaf.master),
        .ins_count_o (ins_count_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        test_req_i = 1'b0;
        ins_req_i  = 1'b0;
        eaf.eaf_resp_i   = 1'b0;
        eaf.eaf_exists_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Issues one lone request and plays the filter: response in command cycle lat (0 = never)
    task automatic do_cmd(input bit ins, input logic [AW-1:0] a, input int lat, input bit ex,
                          output int ack_c, output bit hit, output int hi);
        ack_c = 0;
        hit   = 1'b0;
        hi    = 0;
        if (ins) begin
            ins_req_i = 1'b1; ins_addr_i = a;
        end else begin
            test_req_i = 1'b1; test_addr_i = a;
        end
        tick();
        for (int c = 1; c <= 40 && ack_c == 0; c++) begin
            eaf.eaf_resp_i   = (c == lat);
            eaf.eaf_exists_i = (c == lat) && ex;
            @(negedge clk);
            if (ins ? eaf.eaf_insert_o : eaf.eaf_test_o) hi++;
            if (ins ? ins_ack_o : test_ack_o) begin
                ack_c = c;
                hit   = test_hit_o;
            end
            tick();
        end
        test_req_i = 1'b0;
        ins_req_i  = 1'b0;
        eaf.eaf_resp_i   = 1'b0;
        eaf.eaf_exists_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if ({eaf.eaf_test_o, eaf.eaf_insert_o, eaf.eaf_clear_o} !== 3'b000) begin
            bad++; $display("FAIL reset_cmds: got %b want 000", {eaf.eaf_test_o, eaf.eaf_insert_o, eaf.eaf_clear_o}); end
        total++; if (eaf.eaf_addr_o !== '0) begin
            bad++; $display("FAIL reset_addr: got %0h want 0", eaf.eaf_addr_o); end
        total++; if ({test_ack_o, ins_ack_o, busy_o, err_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {test_ack_o, ins_ack_o, busy_o, err_o}); end
        total++; if (ins_count_o !== '0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", ins_count_o); end
        tick();
    endtask

    task automatic test_single();
        int ack_c; bit hit; int hi;
        do_cmd(1'b0, 32'h1000, 2, 1'b1, ack_c, hit, hi);
        total++; if (ack_c !== 2) begin bad++; $display("FAIL single_ack_cycle: got %0d want 2", ack_c); end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL single_hit: got %0b want 1", hit); end
        total++; if (hi !== 2) begin bad++; $display("FAIL single_test_high: got %0d want 2", hi); end
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %0b want 0", busy_o); end
        total++; if (test_ack_o !== 1'b0) begin bad++; $display("FAIL single_no_regrant: got %0b want 0", test_ack_o); end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        test_req_i = 1'b1; test_addr_i = 32'hA0;
        ins_req_i  = 1'b1; ins_addr_i  = 32'hB0;
        tick();
        eaf.eaf_resp_i = 1'b1; eaf.eaf_exists_i = 1'b0;
        @(negedge clk);
        total++; if ({eaf.eaf_test_o, eaf.eaf_insert_o} !== 2'b10) begin
            bad++; $display("FAIL tie_first_grant: got %b want 10", {eaf.eaf_test_o, eaf.eaf_insert_o}); end
        total++; if (eaf.eaf_addr_o !== 32'hA0) begin bad++; $display("FAIL tie_first_addr: got %0h want a0", eaf.eaf_addr_o); end
        total++; if (test_ack_o !== 1'b1) begin bad++; $display("FAIL tie_test_ack: got %0b want 1", test_ack_o); end
        tick();
        test_req_i = 1'b0; eaf.eaf_resp_i = 1'b0;
        @(negedge clk);
        total++; if ({busy_o, eaf.eaf_insert_o} !== 2'b00) begin
            bad++; $display("FAIL tie_idle_gap: got %b want 00", {busy_o, eaf.eaf_insert_o}); end
        tick();
        eaf.eaf_resp_i = 1'b1;
        @(negedge clk);
        total++; if ({eaf.eaf_test_o, eaf.eaf_insert_o} !== 2'b01) begin
            bad++; $display("FAIL tie_second_grant: got %b want 01", {eaf.eaf_test_o, eaf.eaf_insert_o}); end
        total++; if (eaf.eaf_addr_o !== 32'hB0) begin bad++; $display("FAIL tie_second_addr: got %0h want b0", eaf.eaf_addr_o); end
        total++; if (ins_ack_o !== 1'b1) begin bad++; $display("FAIL tie_ins_ack: got %0b want 1", ins_ack_o); end
        tick();
        ins_req_i = 1'b0; eaf.eaf_resp_i = 1'b0;
    endtask

    task automatic test_capacity();
        int ack_c; bit hit; int hi;
        do_reset();
        for (int i = 0; i < CAP; i++) begin
            do_cmd(1'b1, 32'h4000 + 32'(i * 64), 1 + i % 3, 1'b0, ack_c, hit, hi);
            total++; if (ack_c !== 1 + i % 3) begin bad++; $display("FAIL cap_ack_cycle%0d: got %0d want %0d", i, ack_c, 1 + i % 3); end
            @(negedge clk);
            total++; if (ins_count_o !== CW'(i + 1)) begin bad++; $display("FAIL cap_count%0d: got %0d want %0d", i, ins_count_o, i + 1); end
            total++; if (eaf.eaf_clear_o !== (i == CAP - 1)) begin
                bad++; $display("FAIL cap_clear%0d: got %0b want %0b", i, eaf.eaf_clear_o, i == CAP - 1); end
        end
        tick();
        @(negedge clk);
        total++; if (eaf.eaf_clear_o !== 1'b0) begin bad++; $display("FAIL cap_clear_len: got %0b want 0", eaf.eaf_clear_o); end
        total++; if (ins_count_o !== '0) begin bad++; $display("FAIL cap_count_cleared: got %0d want 0", ins_count_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL cap_busy_after: got %0b want 0", busy_o); end
    endtask

    task automatic test_timeout();
        int ack_c; bit hit; int hi;
        do_reset();
        do_cmd(1'b0, 32'h2000, 0, 1'b1, ack_c, hit, hi);
        total++; if (ack_c !== TO) begin bad++; $display("FAIL to_test_ack_cycle: got %0d want %0d", ack_c, TO); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL to_test_hit: got %0b want 0", hit); end
        total++; if (hi !== TO) begin bad++; $display("FAIL to_test_high: got %0d want %0d", hi, TO); end
        @(negedge clk);
        total++; if ({err_o, busy_o} !== 2'b10) begin bad++; $display("FAIL to_err_idle: got %b want 10", {err_o, busy_o}); end
        do_cmd(1'b0, 32'h3000, 1, 1'b1, ack_c, hit, hi);
        total++; if ({ack_c == 1, hit} !== 2'b11) begin bad++; $display("FAIL to_recover: got ack=%0d hit=%0b want 1 1", ack_c, hit); end
        do_cmd(1'b1, 32'h3040, 0, 1'b0, ack_c, hit, hi);
        total++; if (ack_c !== TO) begin bad++; $display("FAIL to_ins_ack_cycle: got %0d want %0d", ack_c, TO); end
        @(negedge clk);
        total++; if (ins_count_o !== '0) begin bad++; $display("FAIL to_ins_no_count: got %0d want 0", ins_count_o); end
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %0b want 1", err_o); end
    endtask

    task automatic test_reset_mid();
        int ack_c; bit hit; int hi;
        do_reset();
        do_cmd(1'b1, 32'h500, 1, 1'b0, ack_c, hit, hi);
        do_cmd(1'b1, 32'h540, 2, 1'b0, ack_c, hit, hi);
        ins_req_i = 1'b1; ins_addr_i = 32'h580;
        tick();
        eaf.eaf_resp_i = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (ins_ack_o !== 1'b0) begin bad++; $display("FAIL rstmid_no_ack: got %0b want 0", ins_ack_o); end
        tick();
        ins_req_i = 1'b0; eaf.eaf_resp_i = 1'b0;
        @(negedge clk);
        total++; if (ins_count_o !== '0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", ins_count_o); end
        total++; if ({eaf.eaf_insert_o, busy_o, err_o} !== 3'b000) begin
            bad++; $display("FAIL rstmid_outputs: got %b want 000", {eaf.eaf_insert_o, busy_o, err_o}); end
        total++; if (eaf.eaf_addr_o !== '0) begin bad++; $display("FAIL rstmid_addr: got %0h want 0", eaf.eaf_addr_o); end
        tick();
        rst = 1'b1;
    endtask

    // Cycle-level traffic against a transaction model: pending requests, round-robin order,
    // an address set standing in for the filter, and the insertion count
    task automatic run_traffic(input int ncyc, input int pct, input bit hold,
                               output int n_t, output int n_i, output int alt_bad);
        bit            inset [logic [31:0]];
        logic [31:0]   pool [6];
        int            m_state, m_cnt, k, lat, last_g, g;
        bit            m_last_ins, drop_t, drop_i, resp_now, ex_now;
        logic [31:0]   m_addr;
        pool = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
        m_state = 0; m_cnt = 0; k = 0; lat = 1; last_g = -1;
        m_last_ins = 1'b1; drop_t = 1'b0; drop_i = 1'b0; m_addr = '0;
        n_t = 0; n_i = 0; alt_bad = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (drop_t) begin
                if (hold) test_addr_i = pool[$urandom_range(5)]; else test_req_i = 1'b0;
            end else if (!test_req_i && $urandom_range(99) < pct) begin
                test_req_i = 1'b1; test_addr_i = pool[$urandom_range(5)];
            end
            if (drop_i) begin
                if (hold) ins_addr_i = pool[$urandom_range(5)]; else ins_req_i = 1'b0;
            end else if (!ins_req_i && $urandom_range(99) < pct) begin
                ins_req_i = 1'b1; ins_addr_i = pool[$urandom_range(5)];
            end
            drop_t = 1'b0; drop_i = 1'b0;
            if (m_state == 1 || m_state == 2) begin
                k++;
                resp_now = (k == lat);
            end else begin
                resp_now = ($urandom_range(7) == 0);
            end
            ex_now = (resp_now && m_state == 1) ? inset.exists(m_addr) : 1'($urandom_range(1));
            eaf.eaf_resp_i   = resp_now;
            eaf.eaf_exists_i = ex_now;
            @(negedge clk);
            total++; if ({eaf.eaf_test_o, eaf.eaf_insert_o, eaf.eaf_clear_o} !== {m_state == 1, m_state == 2, m_state == 3}) begin
                bad++; $display("FAIL rnd_cmd c%0d: got %b want %b", cyc, {eaf.eaf_test_o, eaf.eaf_insert_o, eaf.eaf_clear_o},
                                {m_state == 1, m_state == 2, m_state == 3}); end
            total++; if (busy_o !== (m_state != 0)) begin bad++; $display("FAIL rnd_busy c%0d: got %0b want %0b", cyc, busy_o, m_state != 0); end
            total++; if (ins_count_o !== CW'(m_cnt)) begin bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, ins_count_o, m_cnt); end
            total++; if ({test_ack_o, ins_ack_o} !== {m_state == 1 && resp_now, m_state == 2 && resp_now}) begin
                bad++; $display("FAIL rnd_ack c%0d: got %b want %b", cyc, {test_ack_o, ins_ack_o},
                                {m_state == 1 && resp_now, m_state == 2 && resp_now}); end
            if (m_state == 1 && resp_now) begin
                total++; if (test_hit_o !== inset.exists(m_addr)) begin
                    bad++; $display("FAIL rnd_hit c%0d: got %0b want %0b", cyc, test_hit_o, inset.exists(m_addr)); end
            end
            if (m_state == 1 || m_state == 2) begin
                total++; if (eaf.eaf_addr_o !== m_addr) begin bad++; $display("FAIL rnd_addr c%0d: got %0h want %0h", cyc, eaf.eaf_addr_o, m_addr); end
            end
            @(posedge clk);
            case (m_state)
                0: begin
                    g = 0;
                    if (test_req_i && ins_req_i) g = m_last_ins ? 1 : 2;
                    else if (test_req_i) g = 1;
                    else if (ins_req_i) g = 2;
                    if (g != 0) begin
                        m_state = g;
                        m_last_ins = (g == 2);
                        m_addr = (g == 1) ? test_addr_i : ins_addr_i;
                        k = 0;
                        lat = $urandom_range(1, 4);
                        if (g == 1) n_t++; else n_i++;
                        if (last_g == g) alt_bad++;
                        last_g = g;
                    end
                end
                1: if (resp_now) begin m_state = 0; drop_t = 1'b1; end
                2: if (resp_now) begin
                    m_cnt++;
                    inset[m_addr] = 1'b1;
                    drop_i = 1'b1;
                    m_state = (m_cnt == CAP) ? 3 : 0;
                end
                default: begin m_cnt = 0; inset.delete(); m_state = 0; end
            endcase
            #1;
        end
        test_req_i = 1'b0; ins_req_i = 1'b0;
        eaf.eaf_resp_i = 1'b0; eaf.eaf_exists_i = 1'b0;
    endtask

    task automatic test_random();
        int n_t, n_i, alt_bad;
        do_reset();
        run_traffic(400, 40, 1'b0, n_t, n_i, alt_bad);
        total++; if (n_t < 5 || n_i < 5) begin bad++; $display("FAIL rnd_activity: got t=%0d i=%0d want >=5 each", n_t, n_i); end
    endtask

    task automatic test_back_to_back();
        int n_t, n_i, alt_bad;
        do_reset();
        run_traffic(200, 100, 1'b1, n_t, n_i, alt_bad);
        total++; if (alt_bad !== 0) begin bad++; $display("FAIL b2b_alternate: got %0d repeats want 0", alt_bad); end
        total++; if (n_t < 10 || n_t - n_i > 1 || n_i - n_t > 1) begin
            bad++; $display("FAIL b2b_balance: got t=%0d i=%0d want equal within 1", n_t, n_i); end
    endtask

    initial begin
        eaf.eaf_resp_i   = 1'b0;
        eaf.eaf_exists_i = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_capacity();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
